// File: rtl/accum_pkg.sv
// Shared types and width helpers for the read-and-accumulate sequencer.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    LOAD,
    DONE
  } state_t;

  // Wide enough for RD_LAT up to 15.
  localparam int unsigned LAT_CNT_W = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned addr_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/accum_datapath.sv
// Accumulator and published-result registers for the sequencer.
module accum_datapath #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SUM_W  = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              add_i,
  input  logic              commit_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [SUM_W-1:0]  result_o
);

  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] result_q, result_d;
  logic [SUM_W-1:0] sum;

  assign sum = acc_q + SUM_W'(data_i);

  always_comb begin
    acc_d    = acc_q;
    result_d = result_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = sum;
    end
    // The final word is folded straight into the result, not read back from acc.
    if (commit_i) begin
      result_d = sum;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/accum_seq_ctrl.sv
// Read-and-accumulate sequencer: walks a latency-RD_LAT read port and sums NUM_WORDS words.
module accum_seq_ctrl
  import accum_pkg::*;
#(
  parameter  int unsigned NUM_WORDS = 4,
  parameter  int unsigned RD_LAT    = 1,
  parameter  int unsigned DATA_W    = 16,
  localparam int unsigned ADDR_W    = addr_width(NUM_WORDS),
  localparam int unsigned SUM_W     = DATA_W + clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] address_r,
  output logic              load,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  result
);

  localparam state_t                  FIRST_ST  = (RD_LAT == 0) ? LOAD : WAIT;
  localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [LAT_CNT_W-1:0]    LAT_LAST  = LAT_CNT_W'((RD_LAT == 0) ? 0 : RD_LAT - 1);

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   load_q, busy_q, done_q;
  logic                   clear, add, commit;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    add     = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start && !abort) begin
          clear   = 1'b1;
          cnt_d   = '0;
          state_d = FIRST_ST;
        end
      end
      WAIT: begin
        if (abort) begin
          addr_d  = '0;
          state_d = IDLE;
        end else if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD: begin
        // An aborted LOAD still shows load=1 (registered) but its word is dropped.
        if (abort) begin
          addr_d  = '0;
          state_d = IDLE;
        end else begin
          add = 1'b1;
          if (addr_q < LAST_ADDR) begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = '0;
            state_d = FIRST_ST;
          end else begin
            commit  = 1'b1;
            addr_d  = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        addr_d = '0;
        if (continuous && !abort) begin
          clear   = 1'b1;
          cnt_d   = '0;
          state_d = FIRST_ST;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        addr_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      load_q  <= (state_d == LOAD);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  accum_datapath #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (clear),
    .add_i    (add),
    .commit_i (commit),
    .data_i   (data_in),
    .result_o (result)
  );

  assign address_r = addr_q;
  assign load      = load_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Directed self-checking bench for accum_seq_ctrl: default build plus an RD_LAT=0, 8-word build.
module tb_accum_seq_ctrl;

  logic        clk;
  logic        reset;

  logic        start_a, abort_a, cont_a;
  logic [15:0] data_a;
  logic [1:0]  addr_a;
  logic        load_a, busy_a, done_a;
  logic [17:0] result_a;
  logic [15:0] mem_a [4];

  logic        start_b, abort_b, cont_b;
  logic [15:0] data_b;
  logic [2:0]  addr_b;
  logic        load_b, busy_b, done_b;
  logic [18:0] result_b;

  int checks;
  int errors;

  accum_seq_ctrl u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start_a),
    .abort      (abort_a),
    .continuous (cont_a),
    .data_in    (data_a),
    .address_r  (addr_a),
    .load       (load_a),
    .busy       (busy_a),
    .done       (done_a),
    .result     (result_a)
  );

  accum_seq_ctrl #(
    .NUM_WORDS (8),
    .RD_LAT    (0),
    .DATA_W    (16)
  ) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start_b),
    .abort      (abort_b),
    .continuous (cont_b),
    .data_in    (data_b),
    .address_r  (addr_b),
    .load       (load_b),
    .busy       (busy_b),
    .done       (done_b),
    .result     (result_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle read latency memory model for the default build.
  always @(posedge clk) data_a <= mem_a[addr_a];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem(input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3);
    mem_a[0] = d0;
    mem_a[1] = d1;
    mem_a[2] = d2;
    mem_a[3] = d3;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #10;
    checks++;
    if ({addr_a, load_a, busy_a, done_a} !== 5'b0 || result_a !== 18'd0) begin
      errors++;
      $display("FAIL reset_a: got addr=%0d load=%0b busy=%0b done=%0b result=%0d, expected all 0",
               addr_a, load_a, busy_a, done_a, result_a);
    end
    checks++;
    if ({addr_b, load_b, busy_b, done_b} !== 6'b0 || result_b !== 19'd0) begin
      errors++;
      $display("FAIL reset_b: got addr=%0d load=%0b busy=%0b done=%0b result=%0h, expected all 0",
               addr_b, load_b, busy_b, done_b, result_b);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int          exp_addr [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    logic [9:0]  exp_load = 10'b0010101010; // bit c-1 for cycle c
    logic        el;
    load_mem(16'd10, 16'd20, 16'd30, 16'd40);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      el = exp_load[c-1];
      checks++;
      if (load_a !== el) begin
        errors++;
        $display("FAIL basic_load c=%0d: got %0b expected %0b", c, load_a, el);
      end
      checks++;
      if (addr_a !== 2'(exp_addr[c-1])) begin
        errors++;
        $display("FAIL basic_addr c=%0d: got %0d expected %0d", c, addr_a, exp_addr[c-1]);
      end
      checks++;
      if (done_a !== (c == 9)) begin
        errors++;
        $display("FAIL basic_done c=%0d: got %0b expected %0b", c, done_a, (c == 9));
      end
      checks++;
      if (busy_a !== (c <= 9)) begin
        errors++;
        $display("FAIL basic_busy c=%0d: got %0b expected %0b", c, busy_a, (c <= 9));
      end
      if (c == 9) begin
        checks++;
        if (result_a !== 18'd100) begin
          errors++;
          $display("FAIL basic_result: got %0d expected 100", result_a);
        end
      end
      step();
    end
  endtask

  task automatic test_rdlat0();
    data_b  = 16'hFFFF;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      checks++;
      if (load_b !== (c <= 8)) begin
        errors++;
        $display("FAIL lat0_load c=%0d: got %0b expected %0b", c, load_b, (c <= 8));
      end
      checks++;
      if (addr_b !== ((c <= 8) ? 3'(c - 1) : 3'd0)) begin
        errors++;
        $display("FAIL lat0_addr c=%0d: got %0d expected %0d", c, addr_b, (c <= 8) ? c - 1 : 0);
      end
      checks++;
      if (done_b !== (c == 9)) begin
        errors++;
        $display("FAIL lat0_done c=%0d: got %0b expected %0b", c, done_b, (c == 9));
      end
      if (c == 9) begin
        checks++;
        if (result_b !== 19'h7FFF8) begin
          errors++;
          $display("FAIL lat0_result: got %0h expected 7fff8", result_b);
        end
      end
      step();
    end
  endtask

  task automatic test_abort();
    load_mem(16'd1, 16'd2, 16'd3, 16'd4);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (done_a !== 1'b0) begin
        errors++;
        $display("FAIL abort_pre_done c=%0d: got %0b expected 0", c, done_a);
      end
      if (c == 5) begin
        checks++;
        if (addr_a !== 2'd2 || busy_a !== 1'b1) begin
          errors++;
          $display("FAIL abort_c5: got addr=%0d busy=%0b expected addr=2 busy=1", addr_a, busy_a);
        end
        abort_a = 1'b1;
      end
      step();
    end
    abort_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || load_a !== 1'b0 || addr_a !== 2'd0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%0b load=%0b addr=%0d expected 0 0 0", busy_a, load_a, addr_a);
    end
    for (int c = 6; c <= 10; c++) begin
      checks++;
      if (done_a !== 1'b0 || result_a !== 18'd100) begin
        errors++;
        $display("FAIL abort_hold c=%0d: got done=%0b result=%0d expected done=0 result=100",
                 c, done_a, result_a);
      end
      step();
    end
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      checks++;
      if (done_a !== (c == 9)) begin
        errors++;
        $display("FAIL abort_next_done c=%0d: got %0b expected %0b", c, done_a, (c == 9));
      end
      if (c == 9) begin
        checks++;
        if (result_a !== 18'd10) begin
          errors++;
          $display("FAIL abort_next_result: got %0d expected 10", result_a);
        end
      end
      step();
    end
  endtask

  task automatic test_continuous();
    load_mem(16'd5, 16'd5, 16'd5, 16'd5);
    cont_a  = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 38; c++) begin
      if (c == 28) cont_a = 1'b0;
      checks++;
      if (done_a !== (c % 9 == 0 && c <= 36)) begin
        errors++;
        $display("FAIL cont_done c=%0d: got %0b expected %0b", c, done_a, (c % 9 == 0 && c <= 36));
      end
      checks++;
      if (busy_a !== (c <= 36)) begin
        errors++;
        $display("FAIL cont_busy c=%0d: got %0b expected %0b", c, busy_a, (c <= 36));
      end
      if (c % 9 == 0 && c <= 36) begin
        checks++;
        if (result_a !== 18'd20) begin
          errors++;
          $display("FAIL cont_result c=%0d: got %0d expected 20", c, result_a);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic el;
    load_mem(16'd10, 16'd20, 16'd30, 16'd40);
    start_a = 1'b1;
    step();
    for (int c = 1; c <= 33; c++) begin
      if (c == 30) start_a = 1'b0;
      el = (c < 30) && ((c % 10) inside {2, 4, 6, 8});
      checks++;
      if (load_a !== el) begin
        errors++;
        $display("FAIL b2b_load c=%0d: got %0b expected %0b", c, load_a, el);
      end
      checks++;
      if (done_a !== (c == 9 || c == 19 || c == 29)) begin
        errors++;
        $display("FAIL b2b_done c=%0d: got %0b expected %0b", c, done_a, (c == 9 || c == 19 || c == 29));
      end
      checks++;
      if (busy_a !== !(c == 10 || c == 20 || c >= 30)) begin
        errors++;
        $display("FAIL b2b_busy c=%0d: got %0b expected %0b", c, busy_a, !(c == 10 || c == 20 || c >= 30));
      end
      if (c == 9 || c == 19 || c == 29) begin
        checks++;
        if (result_a !== 18'd100) begin
          errors++;
          $display("FAIL b2b_result c=%0d: got %0d expected 100", c, result_a);
        end
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    step();
    step();
    checks++;
    if (load_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL mreset_pre c=4: got load=%0b busy=%0b expected 1 1", load_a, busy_a);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({addr_a, load_a, busy_a, done_a} !== 5'b0 || result_a !== 18'd0) begin
      errors++;
      $display("FAIL mreset_a: got addr=%0d load=%0b busy=%0b done=%0b result=%0d expected all 0",
               addr_a, load_a, busy_a, done_a, result_a);
    end
    checks++;
    if (result_b !== 19'd0) begin
      errors++;
      $display("FAIL mreset_b: got result=%0h expected 0", result_b);
    end
    #3;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (busy_a !== 1'b0 || load_a !== 1'b0 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL mreset_idle c=%0d: got busy=%0b load=%0b done=%0b expected 0 0 0",
                 c, busy_a, load_a, done_a);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    start_a = 1'b0;
    abort_a = 1'b0;
    cont_a  = 1'b0;
    start_b = 1'b0;
    abort_b = 1'b0;
    cont_b  = 1'b0;
    data_b  = 16'h0000;
    load_mem(16'd0, 16'd0, 16'd0, 16'd0);
    test_reset();
    test_basic();
    test_rdlat0();
    test_abort();
    test_continuous();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_seq_ctrl.md
# accum_seq_ctrl

Parametrised read-and-accumulate sequencer for the frequency-meter datapath. On a start request it walks a read address from 0 to NUM_WORDS-1 over a synchronous memory or register bank with RD_LAT cycles of read latency. It pulses `load` when each word is valid, sums the words internally, and publishes the total with a one-cycle `done`. It also supports an abort and a free-running continuous mode.

## Interface
- NUM_WORDS, 4: words per pass, ≥2.
- RD_LAT, 1: cycles from address change to valid `data_in`, 0..15.
- DATA_W, 16: width of `data_in`.
- ADDR_W, derived: clog2(NUM_WORDS), minimum 1.
- SUM_W, derived: DATA_W + clog2(NUM_WORDS).

Ports:
- clk  in  1  single clock; everything is on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  level, sampled in IDLE; 1 begins a pass.
- abort  in  1  sampled every cycle; 1 kills the current pass.
- continuous  in  1  sampled in DONE; 1 starts the next pass immediately.
- data_in  in  DATA_W  read data for `address_r`, valid RD_LAT cycles after the address changes.
- address_r  out  ADDR_W  current read address.
- load  out  1  `data_in` is being accumulated this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; `result` holds the new total.
- result  out  SUM_W  last completed sum; held until the next completed pass.

## Operation
- States: IDLE, WAIT, LOAD, DONE. A WAIT counter runs 0..RD_LAT-1.
- IDLE: `address_r`=0. When start=1 and abort=0: clear acc, go to WAIT (or LOAD if RD_LAT=0).
- WAIT: hold `address_r`. When the counter reaches RD_LAT-1, go to LOAD.
- LOAD: `load`=1 and acc <= acc + data_in.
  - If `address_r` < NUM_WORDS-1: increment `address_r`, go to WAIT (or LOAD if RD_LAT=0).
  - Otherwise: result <= acc + data_in, go to DONE.
- DONE: `done`=1 and `address_r`=0.
  - If continuous=1 and abort=0: clear acc, go to WAIT (or LOAD if RD_LAT=0).
  - Otherwise: go to IDLE.
- Abort: abort=1 in WAIT or LOAD forces IDLE next cycle.
  - `result` is not updated and `done` is not pulsed.
  - A LOAD cycle that coincides with abort still shows `load`=1, but its data is discarded.
- Priority: abort beats start and continuous. start is ignored while `busy`=1.
- Arithmetic: unsigned. SUM_W is sized so a pass cannot overflow, and there is no wrap.
- Reset values: state IDLE, `address_r`=0, `load`=0, `busy`=0, `done`=0, `result`=0, acc=0.

## Timing
- start is accepted at edge E0. Word i is loaded in cycle (i+1)·(RD_LAT+1) after E0.
- `done` is high in cycle NUM_WORDS·(RD_LAT+1)+1 after E0.
  - Defaults: loads in cycles 2, 4, 6, 8; `done` in cycle 9.
- `address_r` changes only on the edge leaving LOAD (increment) or entering DONE (reset to 0). It is stable for RD_LAT+1 cycles per word.
- `result` changes on the same edge at which `done` rises and is valid throughout the `done` cycle.
- Continuous mode: the next pass's first WAIT (or LOAD) cycle directly follows DONE, with no IDLE gap. Period = NUM_WORDS·(RD_LAT+1)+1 cycles.
- RD_LAT=0: no WAIT cycles; LOAD runs for NUM_WORDS consecutive cycles.
- Reset asserted mid-pass: outputs go to their reset values immediately (asynchronous). The first pass after deassertion needs a fresh start.

## Structure
- Shared package `accum_pkg`: state enum (IDLE, WAIT, LOAD, DONE) and the clog2 helper used to derive ADDR_W and SUM_W.
- One natural sub-module, `accum_datapath`:
  - contains the acc and `result` registers;
  - inputs: clear, add, commit.
  - The FSM, the address counter and the WAIT counter stay in the top level.

## Test plan
- Defaults; start pulse with data[a] = 10, 20, 30, 40 → `load` in cycles 2, 4, 6, 8; `address_r` 0,0,1,1,2,2,3,3; `done` in cycle 9; `result`=100; `busy` low in cycle 10.
- RD_LAT=0, NUM_WORDS=8, all data 0xFFFF → 8 consecutive `load` cycles; `done` in cycle 9; `result`=0x7FFF8 (SUM_W=19, no overflow).
- abort asserted in cycle 5 of a default pass that follows a completed pass with result=100 → IDLE in cycle 6; no `done`; `result` stays 100; next start sums correctly from 0.
- continuous=1 held, data constant 5 → `done` every 9 cycles; `result`=20 each time; `busy` never drops; deasserting continuous → IDLE after the next `done`.
- start held high for 30 cycles with continuous=0 → first pass completes; a second pass starts from IDLE one cycle after DONE; starts while `busy`=1 have no effect.
- reset asserted in cycle 4, between clock edges → all outputs 0 immediately; after release with start=0, the block stays in IDLE.
